// File: rtl/muldiv_seq.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models mult/div latency with a
// down-counter and stalls decode for HI/LO-class instructions while an operation is pending.
module muldiv_seq #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   input  logic        cancel,
   input  logic        md_instr_d,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   // state | meaning
   // IDLE  | cnt == 0; accepts start and mthi/mtlo
   // BUSY  | cnt != 0; counting down, result lands on the 1 -> 0 edge

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [1:0]    op_q;
   logic [31:0]   a_q, b_q;

   logic          accept, mt_ok;
   logic [63:0]   prod_s, prod_u, res;
   logic          neg_a, neg_b, res_we;
   logic [31:0]   abs_a, abs_b, dsor, uq, ur, quo, rem;

   assign busy   = (state == BUSY);
   assign accept = start & ~cancel & (state == IDLE);
   // a start in the same cycle always wins over mthi/mtlo
   assign mt_ok  = ~cancel & ~start & (state == IDLE);
   assign stall  = md_instr_d & (busy | (start & ~cancel));

   // Signed divide goes through magnitudes; 0x80000000 / -1 falls out as 0x80000000, rem 0.
   always_comb begin
      prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      prod_u = {32'h0, a_q} * {32'h0, b_q};
      neg_a  = ~op_q[0] & a_q[31];
      neg_b  = ~op_q[0] & b_q[31];
      abs_a  = neg_a ? (~a_q + 32'd1) : a_q;
      abs_b  = neg_b ? (~b_q + 32'd1) : b_q;
      dsor   = (abs_b == 32'd0) ? 32'd1 : abs_b;
      uq     = abs_a / dsor;
      ur     = abs_a % dsor;
      quo    = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
      rem    = neg_a ? (~ur + 32'd1) : ur;
      res    = op_q[1] ? {rem, quo} : (op_q[0] ? prod_u : prod_s);
      res_we = ~op_q[1] | (b_q != 32'd0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q  <= op;
                  a_q   <= a;
                  b_q   <= b;
                  cnt   <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                  state <= BUSY;
               end else begin
                  if (hi_we & mt_ok) hi <= wdata;
                  if (lo_we & mt_ok) lo <= wdata;
               end
            end
            BUSY: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= IDLE;
                  if (res_we) begin
                     hi <= res[63:32];
                     lo <= res[31:0];
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected HI/LO and busy length,
// a monitor pops and compares on every busy 1 -> 0 transition.
module tb_muldiv_seq;
   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset, start, hi_we, lo_we, cancel, md_instr_d;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic        busy, stall;
   logic [31:0] hi, lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          len;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] m_hi, m_lo;
   int          n_checks = 0;
   int          n_err = 0;

   muldiv_seq #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .cancel(cancel),
      .md_instr_d(md_instr_d), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Architectural reference: returns {hi, lo} after the operation.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, y, h, l);
      longint      sx, sy, q, r;
      logic [63:0] ux, uy, res;
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      ux  = {32'h0, x};
      uy  = {32'h0, y};
      res = {h, l};
      case (o)
         2'b00: res = 64'(sx * sy);
         2'b01: res = ux * uy;
         2'b10: if (y != 32'd0) begin
            q   = sx / sy;
            r   = sx % sy;
            res = {r[31:0], q[31:0]};
         end
         default: if (y != 32'd0) res = {x % y, x / y};
      endcase
      return res;
   endfunction

   task automatic push_exp(input logic [1:0] o, input logic [31:0] x, y);
      logic [63:0] r;
      exp_t        e;
      r     = model(o, x, y, m_hi, m_lo);
      m_hi  = r[63:32];
      m_lo  = r[31:0];
      e.hi  = m_hi;
      e.lo  = m_lo;
      e.len = o[1] ? DC : MC;
      sbq.push_back(e);
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] x, y, input logic c);
      start  = 1'b1;
      op     = o;
      a      = x;
      b      = y;
      cancel = c;
      if (!c) push_exp(o, x, y);
      @(posedge clk); #1;
      start  = 1'b0;
      cancel = 1'b0;
      op     = 2'($urandom);
      a      = $urandom;
      b      = $urandom;
   endtask

   task automatic mt(input logic hw, lw, input logic [31:0] d, input logic c);
      hi_we  = hw;
      lo_we  = lw;
      wdata  = d;
      cancel = c;
      @(posedge clk); #1;
      hi_we  = 1'b0;
      lo_we  = 1'b0;
      cancel = 1'b0;
      wdata  = $urandom;
      if (!c) begin
         if (hw) m_hi = d;
         if (lw) m_lo = d;
      end
      chk("mt_hi", hi, m_hi);
      chk("mt_lo", lo, m_lo);
   endtask

   task automatic wait_idle();
      int i = 0;
      while (busy !== 1'b0 && i < 40) begin
         @(posedge clk); #1;
         i++;
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, i);
      end
   endtask

   task automatic mult_stall_run(input logic md, input logic [31:0] x, y);
      md_instr_d = md;
      start      = 1'b1;
      op         = 2'b00;
      a          = x;
      b          = y;
      cancel     = 1'b0;
      push_exp(2'b00, x, y);
      @(negedge clk);
      chk("stall_start", 32'(stall), 32'(md));
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < MC; i++) begin
         @(negedge clk);
         chk("stall_busy", 32'(stall), 32'(md));
      end
      @(negedge clk);
      chk("stall_after", 32'(stall), 32'd0);
      @(posedge clk); #1;
      md_instr_d = 1'b0;
   endtask

   // Monitor: measures busy run length and checks HI/LO when busy falls.
   initial begin
      int   run;
      logic prev;
      exp_t e;
      run  = 0;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            run  = 0;
            prev = 1'b0;
         end else begin
            if (busy === 1'b1) run++;
            else if (prev) begin
               if (sbq.size() == 0) begin
                  n_checks++;
                  n_err++;
                  $display("FAIL unexpected_done: busy fell after %0d cycles, expected no operation", run);
               end else begin
                  e = sbq.pop_front();
                  chk("res_hi", hi, e.hi);
                  chk("res_lo", lo, e.lo);
                  chk("busy_len", 32'(run), 32'(e.len));
               end
               run = 0;
            end
            prev = (busy === 1'b1);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int          k;
      logic [31:0] x, y;
      logic        c;
      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0; cancel = 1'b0; md_instr_d = 1'b0;
      m_hi = '0; m_lo = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);

      issue(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0); wait_idle();
      chk("mult_hi_lit", hi, 32'hFFFFFFFF); chk("mult_lo_lit", lo, 32'hFFFFFFF1);
      issue(2'b01, 32'hFFFFFFFD, 32'd5, 1'b0); wait_idle();
      chk("multu_hi_lit", hi, 32'h00000004); chk("multu_lo_lit", lo, 32'hFFFFFFF1);
      issue(2'b11, 32'd100, 32'd7, 1'b0); wait_idle();
      chk("divu_hi_lit", hi, 32'd2); chk("divu_lo_lit", lo, 32'd14);
      issue(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0); wait_idle();
      chk("div_hi_lit", hi, 32'hFFFFFFFF); chk("div_lo_lit", lo, 32'hFFFFFFFD);
      issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0); wait_idle();
      chk("divovf_hi_lit", hi, 32'd0); chk("divovf_lo_lit", lo, 32'h80000000);

      mt(1'b1, 1'b0, 32'h1234, 1'b0);
      mt(1'b0, 1'b1, 32'h5678, 1'b0);
      issue(2'b10, 32'd55, 32'd0, 1'b0); wait_idle();
      chk("div0_hi_lit", hi, 32'h1234); chk("div0_lo_lit", lo, 32'h5678);
      mt(1'b1, 1'b1, 32'hABCD0000, 1'b1);
      mt(1'b1, 1'b1, 32'hCAFE0001, 1'b0);

      mult_stall_run(1'b1, 32'd7, 32'd9);
      mult_stall_run(1'b0, 32'hFFFFFFFE, 32'hFFFFFFFE);

      issue(2'b01, 32'd3, 32'd3, 1'b1);
      chk("cancel_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1 chk("cancel_busy_later", 32'(busy), 32'd0);
      chk("cancel_hi", hi, m_hi); chk("cancel_lo", lo, m_lo);

      issue(2'b00, 32'd1234567, 32'd89, 1'b0);
      cancel = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1 cancel = 1'b0;
      wait_idle();

      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BADF00D;
      issue(2'b11, 32'd9, 32'd0, 1'b0);
      hi_we = 1'b0; lo_we = 1'b0;
      chk("start_wins_hi", hi, m_hi); chk("start_wins_lo", lo, m_lo);
      wait_idle();

      issue(2'b11, 32'd77, 32'd0, 1'b0);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD0000;
      start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
      chk("busy_wr_hi", hi, m_hi); chk("busy_wr_lo", lo, m_lo);
      wait_idle();

      mt(1'b1, 1'b1, 32'h11112222, 1'b0);
      issue(2'b10, 32'd1000, 32'd3, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1; sbq.delete(); m_hi = '0; m_lo = '0;
      @(posedge clk); #1 reset = 1'b0;
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_hi", hi, 32'd0); chk("rstmid_lo", lo, 32'd0);
      repeat (10) @(posedge clk);
      #1 chk("rstmid_late_busy", 32'(busy), 32'd0);
      chk("rstmid_late_hi", hi, 32'd0); chk("rstmid_late_lo", lo, 32'd0);

      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(0, 9);
         if (k < 2) begin
            mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 7) == 0));
         end else begin
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 5) == 0) y = 32'd0;
            if ($urandom_range(0, 9) == 0) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
            c = ($urandom_range(0, 7) == 0);
            issue(2'($urandom_range(0, 3)), x, y, c);
            if (c) chk("rnd_cancel_busy", 32'(busy), 32'd0);
            else   wait_idle();
         end
      end

      repeat (3) @(posedge clk);
      #1 chk("sb_drained", 32'(sbq.size()), 32'd0);
      chk("final_hi", hi, m_hi);
      chk("final_lo", lo, m_lo);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multiply/divide sequencer for the P7 five-stage MIPS pipeline, sitting in the E stage beside the ALU. It accepts mult/multu/div/divu starts and mthi/mtlo writes from the decoded E-stage instruction, and models the multi-cycle latency with a busy counter. It owns the HI/LO registers and raises the D-stage stall for any HI/LO-class instruction while an operation is pending. Exception cancel suppresses E-stage side effects.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  E-stage instr is mult/multu/div/divu (decoder MultDivStart)
- op  in  2  00 mult, 01 multu, 10 div, 11 divu (decoder MultDivControl)
- a  in  32  forwarded rs value (multiplicand / dividend)
- b  in  32  forwarded rt value (multiplier / divisor)
- hi_we  in  1  E-stage mthi
- lo_we  in  1  E-stage mtlo
- wdata  in  32  forwarded rs value for mthi/mtlo
- cancel  in  1  E-stage instr squashed by exception/interrupt this cycle
- md_instr_d  in  1  D-stage instr is any HI/LO-class op (decoder mdINS)
- busy  out  1  operation in progress
- stall  out  1  freeze F/D, bubble into E
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- State: IDLE (cnt==0) / BUSY (cnt!=0); counter width covers max(MULT_CYCLES, DIV_CYCLES).
- Accept: start & ~cancel & ~busy at edge → latch op, a, b; cnt ← MULT_CYCLES (op[1]==0) or DIV_CYCLES (op[1]==1).
- BUSY: cnt decrements each edge; on edge where cnt goes 1→0, HI/LO written with result, busy falls.
- mult: signed 64-bit product, HI=[63:32], LO=[31:0]. multu: unsigned.
- div: LO=quotient truncated toward zero, HI=remainder with sign of dividend; 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. divu: unsigned.
- Divisor zero (div/divu): full DIV_CYCLES busy, HI/LO left unchanged.
- mthi/mtlo: hi_we & ~cancel & ~busy → HI ← wdata next edge (lo_we → LO); both may assert together.
- start, hi_we, lo_we while busy: ignored (stall prevents this in legal flow).
- start and hi_we/lo_we same cycle: start wins, writes ignored.
- cancel: blocks only the E-stage request that cycle; an operation already in BUSY is never aborted and completes normally.
- stall = md_instr_d & (busy | (start & ~cancel)), combinational.

## Timing
- Reset: cnt=0, busy=0, stall=0 (given md_instr_d=0), hi=0, lo=0; reset mid-operation discards it, HI/LO cleared, no late write.
- Start accepted at edge t → busy=1 during cycles t+1 .. t+N; HI/LO new value visible and busy=0 from cycle t+N+1 onward (N = MULT_CYCLES/DIV_CYCLES).
- Back-to-back: new start accepted in first cycle busy=0 (cycle t+N+1).
- mthi/mtlo at edge t → hi/lo updated from cycle t+1.
- stall asserts same cycle as start (combinational) when md_instr_d=1, deasserts in cycle busy is 0.
- hi/lo outputs are registers; no combinational path from a/b/wdata.

## Test plan
- mult a=0xFFFFFFFD (-3), b=5 → busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; multu same operands → HI=0x00000004, LO=0xFFFFFFF1.
- divu a=100, b=7 → busy 10 cycles, LO=14, HI=2; div a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- div with b=0 after mthi 0x1234/mtlo 0x5678 → busy 10 cycles, HI=0x1234, LO=0x5678 unchanged.
- md_instr_d=1 held from start cycle → stall=1 in start cycle and all 5 busy cycles of mult, 0 after; md_instr_d=0 → stall never asserts.
- start with cancel=1 → busy stays 0, HI/LO unchanged; cancel=1 during BUSY → op completes, result written; hi_we with cancel=1 → HI unchanged.
- reset asserted in 3rd busy cycle of div → next cycle busy=0, hi=lo=0, no write at original completion cycle.
